// File: rtl/gray_bin_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_bin_pipe: pipelined Gray<->binary converter with valid/ready on both  |
// | sides. Optional GRAY_BIN_PIPE_STEP_CHECK_EN adds err_o (mode-0 step check).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gray_bin_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_mode_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
`ifdef GRAY_BIN_PIPE_STEP_CHECK_EN
  output logic                  out_mode_o,
  output logic                  err_o
`else
  output logic                  out_mode_o
`endif
);

  localparam int SDIV  = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK = (DATA_WIDTH + SDIV - 1) / SDIV;

  if (DATA_WIDTH < 2 || STAGES < 1 || STAGES > DATA_WIDTH) begin : g_param_check
    $error("gray_bin_pipe: illegal DATA_WIDTH/STAGES combination");
  end

  logic [STAGES-1:0]                 valid_q, valid_d, mode_q, mode_d, carry_q, carry_d;
  logic [STAGES-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [STAGES-1:0]                 load;
  logic [STAGES-1:0]                 src_valid, src_mode, src_carry, conv_carry;
  logic [STAGES-1:0][DATA_WIDTH-1:0] src_data, conv_data;
  logic                              unused_carry;

  // A slot may load if it or any slot downstream of it is free this cycle.
  always_comb begin
    logic acc;
    acc  = out_ready_i;
    load = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      acc     = acc | ~valid_q[s];
      load[s] = acc;
    end
  end

  always_comb begin
    src_valid[0] = in_valid_i;
    src_mode[0]  = in_mode_i;
    src_data[0]  = in_data_i;
    src_carry[0] = 1'b0;
    for (int s = 1; s < STAGES; s++) begin
      src_valid[s] = valid_q[s-1];
      src_mode[s]  = mode_q[s-1];
      src_data[s]  = data_q[s-1];
      src_carry[s] = carry_q[s-1];
    end
  end

  // Stage s resolves its MSB-first chunk of the prefix XOR; lower bits stay raw Gray.
  always_comb begin
    int                  hi, lo;
    logic                c;
    logic [DATA_WIDTH-1:0] w;
    conv_data  = '0;
    conv_carry = '0;
    for (int s = 0; s < STAGES; s++) begin
      hi = DATA_WIDTH - 1 - s * CHUNK;
      lo = DATA_WIDTH - (s + 1) * CHUNK;
      if (lo < 0) lo = 0;
      w = src_data[s];
      c = src_carry[s];
      if (src_mode[s]) begin
        if (s == 0) w = src_data[s] ^ (src_data[s] >> 1);
      end else begin
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
          if (i <= hi && i >= lo) begin
            c    = c ^ w[i];
            w[i] = c;
          end
        end
      end
      conv_data[s]  = w;
      conv_carry[s] = c;
    end
  end

  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    data_d  = data_q;
    carry_d = carry_q;
    for (int s = 0; s < STAGES; s++) begin
      if (load[s]) begin
        valid_d[s] = src_valid[s];
        if (src_valid[s]) begin
          mode_d[s]  = src_mode[s];
          data_d[s]  = conv_data[s];
          carry_d[s] = conv_carry[s];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      mode_q  <= '0;
      data_q  <= '0;
      carry_q <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      carry_q <= carry_d;
    end
  end

  // The last slot's carry is never consumed; the output word is fully resolved.
  assign unused_carry = carry_q[STAGES-1];

  assign in_ready_o  = load[0];
  assign out_valid_o = valid_q[STAGES-1];
  assign out_data_o  = data_q[STAGES-1];
  assign out_mode_o  = mode_q[STAGES-1];

`ifdef GRAY_BIN_PIPE_STEP_CHECK_EN
  logic [STAGES-1:0]     err_q, err_d, src_err;
  logic [DATA_WIDTH-1:0] ref_q, ref_d;
  logic                  seen_q, seen_d;

  always_comb begin
    src_err[0] = ~in_mode_i & seen_q & ($countones(in_data_i ^ ref_q) > 1);
    for (int s = 1; s < STAGES; s++) src_err[s] = err_q[s-1];
    ref_d  = ref_q;
    seen_d = seen_q;
    err_d  = err_q;
    if (in_valid_i & load[0] & ~in_mode_i) begin
      ref_d  = in_data_i;
      seen_d = 1'b1;
    end
    for (int s = 0; s < STAGES; s++) begin
      if (load[s] & src_valid[s]) err_d[s] = src_err[s];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q  <= '0;
      ref_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      ref_q  <= ref_d;
      seen_q <= seen_d;
    end
  end

  assign err_o = err_q[STAGES-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_bin_pipe.sv
`default_nettype none
// tb_gray_bin_pipe: directed + model-checked bench for gray_bin_pipe (W=8,S=2),
// plus exhaustive Gray sweeps on W=5 S=1/3/5 and W=8 S=8 instances.
module tb_gray_bin_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout/extra beat expected clean completion", nm);
  endtask

  // Reference rules: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] g2b(input logic [31:0] g, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  function automatic int hamming(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (a[i] != b[i]) n++;
    return n;
  endfunction

  logic       rst, sw_rst, sweep_go;
  logic       in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, err;
  logic [7:0] in_data, out_data;

  gray_bin_pipe #(.DATA_WIDTH(8), .STAGES(2)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_mode_i   (in_mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
`ifdef GRAY_BIN_PIPE_STEP_CHECK_EN
    .out_mode_o  (out_mode),
    .err_o       (err)
`else
    .out_mode_o  (out_mode)
`endif
  );
`ifndef GRAY_BIN_PIPE_STEP_CHECK_EN
  assign err = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       m;
    logic       e;
    int         acc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] got_d[$];
  logic       got_m[$];
  logic       got_e[$];
  int         got_lat[$];
  int         got_cyc[$];
  logic [7:0] m_ref;
  logic       m_seen;
  logic       prev_stall;
  logic [7:0] held_d;
  logic       held_m, held_e;

  // Scoreboard: outputs compared on handshake, held values compared during stalls.
  always @(negedge clk) begin : p_compare
    exp_t e;
    if (rst) begin
      exp_q.delete();
      m_seen     = 1'b0;
      m_ref      = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held_d);
        check("stall_mode", out_mode, held_m);
        check("stall_err", err, held_e);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail("unexpected_beat");
        else begin
          e = exp_q.pop_front();
          check("beat_data", out_data, e.d);
          check("beat_mode", out_mode, e.m);
`ifdef GRAY_BIN_PIPE_STEP_CHECK_EN
          check("beat_err", err, e.e);
`endif
          got_d.push_back(out_data);
          got_m.push_back(out_mode);
          got_e.push_back(err);
          got_lat.push_back(cyc - e.acc);
          got_cyc.push_back(cyc);
        end
      end
      prev_stall = out_valid && !out_ready;
      held_d = out_data;
      held_m = out_mode;
      held_e = err;
      if (in_valid && in_ready) begin
        e.m   = in_mode;
        e.acc = cyc;
        e.e   = 1'b0;
        if (in_mode) e.d = in_data ^ (in_data >> 1);
        else begin
          e.d    = g2b({24'd0, in_data}, 8);
          e.e    = m_seen && (hamming(in_data, m_ref) >= 2);
          m_ref  = in_data;
          m_seen = 1'b1;
        end
        exp_q.push_back(e);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic m);
    logic f;
    int   g;
    f = 1'b0;
    g = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    while (!f && g < 200) begin
      @(negedge clk);
      f = in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    if (!f) fail("send_timeout");
    in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    int t;
    t = 0;
    while (got_d.size() < n && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (got_d.size() < n) fail("wait_outs_timeout");
  endtask

  task automatic expect_out(input int idx, input logic [7:0] d, input logic m, input string nm);
    check({nm, "_data"}, got_d[idx], d);
    check({nm, "_mode"}, got_m[idx], m);
  endtask

  // Exhaustive Gray sweeps on separately parametrised instances.
  localparam int NSW = 4;
  localparam int SW_W [NSW] = '{5, 5, 5, 8};
  localparam int SW_S [NSW] = '{1, 3, 5, 8};

  for (genvar g = 0; g < NSW; g++) begin : g_sweep
    localparam int W = SW_W[g];
    localparam int S = SW_S[g];
    logic         v, r, ov, om, oe;
    logic [W-1:0] d, od;
    bit           done;
    int unsigned  eq[$];
    int           dq[$];

    gray_bin_pipe #(.DATA_WIDTH(W), .STAGES(S)) u_sw (
      .clk_i       (clk),
      .rst_i       (sw_rst),
      .in_valid_i  (v),
      .in_ready_o  (r),
      .in_data_i   (d),
      .in_mode_i   (1'b0),
      .out_valid_o (ov),
      .out_ready_i (1'b1),
      .out_data_o  (od),
`ifdef GRAY_BIN_PIPE_STEP_CHECK_EN
      .out_mode_o  (om),
      .err_o       (oe)
`else
      .out_mode_o  (om)
`endif
    );
`ifndef GRAY_BIN_PIPE_STEP_CHECK_EN
    assign oe = 1'b0;
`endif

    initial begin
      v = 1'b0;
      d = '0;
      wait (sweep_go);
      @(posedge clk);
      #1;
      for (int k = 0; k < (1 << W); k++) begin
        v = 1'b1;
        d = k[W-1:0];
        @(posedge clk);
        #1;
      end
      v = 1'b0;
      repeat (S + 3) @(posedge clk);
      #1;
      check($sformatf("sweep_w%0d_s%0d_drain", W, S), eq.size(), 0);
      done = 1'b1;
    end

    always @(negedge clk) begin : p_sweep_chk
      if (!sw_rst) begin
        if (ov) begin
          if (eq.size() == 0) fail($sformatf("sweep_w%0d_s%0d_extra", W, S));
          else begin
            check($sformatf("sweep_w%0d_s%0d_data", W, S), 32'(od), eq.pop_front());
            check($sformatf("sweep_w%0d_s%0d_latency", W, S), cyc, dq.pop_front());
            check($sformatf("sweep_w%0d_s%0d_mode", W, S), {om, oe}, 0);
          end
        end else if (dq.size() > 0 && dq[0] <= cyc) begin
          fail($sformatf("sweep_w%0d_s%0d_missing", W, S));
          void'(eq.pop_front());
          void'(dq.pop_front());
        end
        if (v) begin
          check($sformatf("sweep_w%0d_s%0d_ready", W, S), r, 1);
          eq.push_back(g2b(32'(d), W));
          dq.push_back(cyc + S);
        end
      end
    end
  end

  bit stress_done;

  initial begin
    int base;
    int t;
    rst = 1'b1;
    sw_rst = 1'b1;
    sweep_go = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_mode = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_mode", out_mode, 0);
    check("reset_err", err, 0);
    rst = 1'b0;
    sw_rst = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1);
    sweep_go = 1'b1;
    @(posedge clk);
    #1;

    // Gray->binary with latency 2.
    base = got_d.size();
    send(8'hC0, 1'b0);
    send(8'h80, 1'b0);
    send(8'h00, 1'b0);
    wait_outs(base + 3);
    expect_out(base, 8'h80, 1'b0, "g2b_c0");
    expect_out(base + 1, 8'hFF, 1'b0, "g2b_80");
    expect_out(base + 2, 8'h00, 1'b0, "g2b_00");
    for (int i = 0; i < 3; i++) check("g2b_latency", got_lat[base + i], 2);

    // Binary->Gray, then back-to-back mixed modes.
    base = got_d.size();
    send(8'h05, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h07, 1'b0);
    send(8'h05, 1'b1);
    wait_outs(base + 4);
    expect_out(base, 8'h07, 1'b1, "b2g_05");
    expect_out(base + 1, 8'h80, 1'b1, "b2g_ff");
    expect_out(base + 2, 8'h05, 1'b0, "mix_g07");
    expect_out(base + 3, 8'h07, 1'b1, "mix_b05");
    check("mix_consecutive", got_cyc[base + 3] - got_cyc[base + 2], 1);

    // Backpressure: two accepts fill the pipe, then in_ready drops.
    base = got_d.size();
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++) send(8'(k), 1'b1);
      end
      begin
        int acc;
        acc = 0;
        repeat (5) begin
          @(negedge clk);
          if (in_valid && in_ready) acc++;
        end
        check("bp_accepts", acc, 2);
        check("bp_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_outs(base + 4);
    expect_out(base, 8'h01, 1'b1, "bp_1");
    expect_out(base + 1, 8'h03, 1'b1, "bp_2");
    expect_out(base + 2, 8'h02, 1'b1, "bp_3");
    expect_out(base + 3, 8'h06, 1'b1, "bp_4");

    // Asynchronous reset with two beats in flight.
    out_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    check("inflight_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    base = got_d.size();
    repeat (6) @(posedge clk);
    #1;
    check("no_stale_beat", got_d.size(), base);

    // Step check right after reset: first mode-0 beat is never flagged.
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'h03, 1'b0);
    send(8'h00, 1'b0);
    wait_outs(base + 4);
    expect_out(base, 8'h00, 1'b0, "step_0");
    expect_out(base + 1, 8'h01, 1'b0, "step_1");
    expect_out(base + 2, 8'h02, 1'b0, "step_2");
    expect_out(base + 3, 8'h00, 1'b0, "step_3");
`ifdef GRAY_BIN_PIPE_STEP_CHECK_EN
    check("step_err_0", got_e[base], 0);
    check("step_err_1", got_e[base + 1], 0);
    check("step_err_2", got_e[base + 2], 0);
    check("step_err_3", got_e[base + 3], 1);
`endif

    // Mixed traffic against the model under random backpressure.
    stress_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) send(8'($urandom), 1'($urandom));
        stress_done = 1'b1;
      end
      begin
        while (!stress_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("stress_drained", exp_q.size(), 0);

    t = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done)
           && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done))
      fail("sweep_timeout");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
